// File: rtl/aes_master_pkg.sv
// Shared types and constants for the AES Avalon-MM initiator: FSM state
// encoding, the AES slave register map and the 128-bit word slicer.
package aes_master_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_KEY,
        S_WR_MSG,
        S_WR_START,
        S_POLL,
        S_RD_DEC,
        S_WR_CLR,
        S_FIN
    } state_t;

    localparam logic [3:0] ADDR_KEY0  = 4'd0;
    localparam logic [3:0] ADDR_MSG0  = 4'd4;
    localparam logic [3:0] ADDR_DEC0  = 4'd8;
    localparam logic [3:0] ADDR_START = 4'd14;
    localparam logic [3:0] ADDR_DONE  = 4'd15;

    // Word k of a 128-bit block; word 0 is the most significant.
    function automatic logic [31:0] word_slice(input logic [127:0] v, input logic [1:0] k);
        return v[7'd127 - {k, 5'd0} -: 32];
    endfunction

endpackage

// File: rtl/avm_single_xact.sv
// Single-transaction Avalon-MM engine. The sequencer holds req (with rd,
// addr, wdata) stable until ack. Writes ack on acceptance; reads ack when
// data is valid, READ_LATENCY cycles after acceptance, strobes low meanwhile.
module avm_single_xact #(
    parameter int READ_LATENCY = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req,
    input  logic        rd,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic        pending,
    output logic [31:0] rdata,
    output logic        avm_cs,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_addr,
    output logic [3:0]  avm_byte_en,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam logic [1:0] LAT_LOAD = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
    localparam logic       LAT_ZERO = (READ_LATENCY == 0);

    logic       wait_reg;
    logic [1:0] lat_cnt_reg;
    logic       strobe;
    logic       accepted;

    assign strobe   = req & ~wait_reg;
    assign accepted = strobe & ~avm_waitrequest;

    // Track an accepted read until its data is due.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wait_reg    <= 1'b0;
            lat_cnt_reg <= 2'd0;
        end else if (wait_reg) begin
            if (lat_cnt_reg == 2'd0) begin
                wait_reg <= 1'b0;
            end else begin
                lat_cnt_reg <= lat_cnt_reg - 2'd1;
            end
        end else if (accepted && rd && !LAT_ZERO) begin
            wait_reg    <= 1'b1;
            lat_cnt_reg <= LAT_LOAD;
        end
    end

    assign ack     = req & (wait_reg ? (lat_cnt_reg == 2'd0) : (accepted & (~rd | LAT_ZERO)));
    assign pending = wait_reg;
    assign rdata   = avm_readdata;

    assign avm_cs        = strobe;
    assign avm_read      = strobe & rd;
    assign avm_write     = strobe & ~rd;
    assign avm_addr      = strobe ? addr : 4'd0;
    assign avm_byte_en   = strobe ? 4'hF : 4'h0;
    assign avm_writedata = (strobe & ~rd) ? wdata : 32'd0;

endmodule

// File: rtl/aes_avalon_master.sv
// Hardware driver for the AES decryption register-file slave: writes key,
// ciphertext and start, polls done, reads back the plaintext, clears start.
// Optional poll timeout: define AES_MASTER_TIMEOUT_EN.
module aes_avalon_master
    import aes_master_pkg::*;
#(
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         CMD_START,
    input  logic [127:0] KEY,
    input  logic [127:0] MSG_ENC,
    output logic [127:0] MSG_DEC,
    output logic         BUSY,
    output logic         DONE,
    output logic         ERR,
    output logic         AVM_CS,
    output logic         AVM_READ,
    output logic         AVM_WRITE,
    output logic [3:0]   AVM_ADDR,
    output logic [3:0]   AVM_BYTE_EN,
    output logic [31:0]  AVM_WRITEDATA,
    input  logic [31:0]  AVM_READDATA,
    input  logic         AVM_WAITREQUEST
);

    state_t         state_reg, state_next;
    logic [1:0]     idx_reg, idx_next;
    logic [127:0]   key_reg, msg_reg, msg_dec_reg;
    logic           busy_reg, done_reg;
    logic           accept;
    logic           req, rd, ack, pending, timeout_hit;
    logic [3:0]     addr;
    logic [31:0]    wdata, rdata;

    assign accept = (state_reg == S_IDLE) && CMD_START;

    avm_single_xact #(.READ_LATENCY(READ_LATENCY)) u_xact (
        .CLK             (CLK),
        .RESET           (RESET),
        .req             (req),
        .rd              (rd),
        .addr            (addr),
        .wdata           (wdata),
        .ack             (ack),
        .pending         (pending),
        .rdata           (rdata),
        .avm_cs          (AVM_CS),
        .avm_read        (AVM_READ),
        .avm_write       (AVM_WRITE),
        .avm_addr        (AVM_ADDR),
        .avm_byte_en     (AVM_BYTE_EN),
        .avm_writedata   (AVM_WRITEDATA),
        .avm_readdata    (AVM_READDATA),
        .avm_waitrequest (AVM_WAITREQUEST)
    );

    // Sequencer: one bus transaction per state/word, advance on ack.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        req        = 1'b0;
        rd         = 1'b0;
        addr       = 4'd0;
        wdata      = 32'd0;
        case (state_reg)
            S_IDLE: begin
                if (CMD_START) begin
                    state_next = S_WR_KEY;
                    idx_next   = 2'd0;
                end
            end
            S_WR_KEY: begin
                req   = 1'b1;
                addr  = ADDR_KEY0 + {2'b00, idx_reg};
                wdata = word_slice(key_reg, idx_reg);
                if (ack) begin
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == 2'd3) state_next = S_WR_MSG;
                end
            end
            S_WR_MSG: begin
                req   = 1'b1;
                addr  = ADDR_MSG0 + {2'b00, idx_reg};
                wdata = word_slice(msg_reg, idx_reg);
                if (ack) begin
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == 2'd3) state_next = S_WR_START;
                end
            end
            S_WR_START: begin
                req   = 1'b1;
                addr  = ADDR_START;
                wdata = 32'd1;
                if (ack) state_next = S_POLL;
            end
            S_POLL: begin
                req  = 1'b1;
                rd   = 1'b1;
                addr = ADDR_DONE;
                // Abandon polling only between transactions, never mid-read.
                if (ack && rdata[0]) begin
                    state_next = S_RD_DEC;
                    idx_next   = 2'd0;
                end else if (timeout_hit && (ack || !pending)) begin
                    state_next = S_WR_CLR;
                end
            end
            S_RD_DEC: begin
                req  = 1'b1;
                rd   = 1'b1;
                addr = ADDR_DEC0 + {2'b00, idx_reg};
                if (ack) begin
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == 2'd3) state_next = S_WR_CLR;
                end
            end
            S_WR_CLR: begin
                req   = 1'b1;
                addr  = ADDR_START;
                wdata = 32'd0;
                if (ack) state_next = S_FIN;
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, captured operands, result and status flags.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg   <= S_IDLE;
            idx_reg     <= 2'd0;
            key_reg     <= 128'd0;
            msg_reg     <= 128'd0;
            msg_dec_reg <= 128'd0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (accept) begin
                key_reg  <= KEY;
                msg_reg  <= MSG_ENC;
                busy_reg <= 1'b1;
                done_reg <= 1'b0;
            end
            if (state_reg == S_RD_DEC && ack) begin
                msg_dec_reg[7'd127 - {idx_reg, 5'd0} -: 32] <= rdata;
            end
            if (state_reg == S_WR_CLR && ack) begin
                busy_reg <= 1'b0;
                done_reg <= 1'b1;
            end
        end
    end

`ifdef AES_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt_reg;
    logic          tmo_reg;
    logic          err_reg;

    assign timeout_hit = (tmo_cnt_reg >= TW'(TIMEOUT_CYCLES - 1));

    // Count cycles spent in POLL, saturating at the budget.
    always_ff @(posedge CLK) begin
        if (RESET || state_reg != S_POLL) begin
            tmo_cnt_reg <= '0;
        end else if (!timeout_hit) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    // Remember an abandoned poll; report it as ERR alongside DONE.
    always_ff @(posedge CLK) begin
        if (RESET || accept) begin
            tmo_reg <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            if (state_reg == S_POLL && state_next == S_WR_CLR) tmo_reg <= 1'b1;
            if (state_reg == S_WR_CLR && ack) err_reg <= tmo_reg;
        end
    end

    assign ERR = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign ERR         = 1'b0;
`endif

    assign MSG_DEC = msg_dec_reg;
    assign BUSY    = busy_reg;
    assign DONE    = done_reg;

endmodule

// File: tb/tb_aes_avalon_master.sv
// Bench for aes_avalon_master: unit 0 (READ_LATENCY=0, TIMEOUT_CYCLES=16)
// and unit 1 (READ_LATENCY=2, random WAITREQUEST), each on a behavioural
// register-file slave whose "decryption" is a lookup/stand-in function.
module tb_aes_avalon_master;

    localparam bit [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam bit [127:0] FIPS_ENC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam bit [127:0] FIPS_DEC = 128'h00112233445566778899aabbccddeeff;
    localparam int NEVER = 1 << 30;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic                rst;
    logic [1:0]          cmd_start, busy, done, err, avm_cs, avm_read, avm_write, waitreq;
    logic [1:0][127:0]   key, msg_enc, msg_dec;
    logic [1:0][3:0]     avm_addr, avm_be;
    logic [1:0][31:0]    avm_wd, avm_rd;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unit
            aes_avalon_master #(
                .READ_LATENCY   (gi * 2),
                .TIMEOUT_CYCLES ((gi == 0) ? 16 : 4096)
            ) dut (
                .CLK             (CLK),
                .RESET           (rst),
                .CMD_START       (cmd_start[gi]),
                .KEY             (key[gi]),
                .MSG_ENC         (msg_enc[gi]),
                .MSG_DEC         (msg_dec[gi]),
                .BUSY            (busy[gi]),
                .DONE            (done[gi]),
                .ERR             (err[gi]),
                .AVM_CS          (avm_cs[gi]),
                .AVM_READ        (avm_read[gi]),
                .AVM_WRITE       (avm_write[gi]),
                .AVM_ADDR        (avm_addr[gi]),
                .AVM_BYTE_EN     (avm_be[gi]),
                .AVM_WRITEDATA   (avm_wd[gi]),
                .AVM_READDATA    (avm_rd[gi]),
                .AVM_WAITREQUEST (waitreq[gi])
            );
        end
    endgenerate

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int both_hi = 0;
    bit wr_rand = 1'b0;

    // Slave model state, per unit.
    bit [31:0] sregs [2][16];
    int        poll_cnt [2];
    int        poll_target [2];
    bit        started [2];
    int        pend [2];
    bit [31:0] pend_val [2];
    int        viol [2];
    bit        prev_stall [2];
    bit [3:0]  prev_a [2];
    bit [31:0] prev_d [2];
    bit        prev_r [2];
    int        log_n [2];
    bit [3:0]  log_a [2][128];
    bit        log_w [2][128];
    bit [31:0] log_d [2][128];

    // Stand-in cipher: true FIPS-197 pair, otherwise an arbitrary mix.
    function automatic bit [127:0] model_dec(bit [127:0] k, bit [127:0] m);
        if (k == FIPS_KEY && m == FIPS_ENC) return FIPS_DEC;
        return k ^ {m[63:0], m[127:64]};
    endfunction

    function automatic bit [31:0] wslice(bit [127:0] v, int i);
        bit [127:0] t;
        t = v >> (96 - 32 * i);
        return t[31:0];
    endfunction

    function automatic bit [31:0] slave_rd(int u, bit [3:0] a);
        if (a == 4'd15) return {31'd0, started[u] && (poll_cnt[u] + 1 >= poll_target[u])};
        return sregs[u][a];
    endfunction

    // Slave inputs change on the falling edge only.
    always @(negedge CLK) begin
        waitreq[0] = 1'b0;
        waitreq[1] = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        avm_rd[0]  = slave_rd(0, avm_addr[0]);
        avm_rd[1]  = (pend[1] == 0) ? pend_val[1] : $urandom;
        if ((busy & done) != 2'b00) both_hi++;
    end

    // Slave register file, transaction log and protocol observation.
    always @(posedge CLK) begin
        for (int u = 0; u < 2; u++) begin
            if (pend[u] >= 0 && avm_cs[u]) viol[u]++;
            if (prev_stall[u] && !(avm_cs[u] && avm_addr[u] == prev_a[u] &&
                                   avm_wd[u] == prev_d[u] && avm_read[u] == prev_r[u])) viol[u]++;
            prev_stall[u] = avm_cs[u] && waitreq[u];
            prev_a[u] = avm_addr[u];
            prev_d[u] = avm_wd[u];
            prev_r[u] = avm_read[u];
            if (pend[u] >= 0) pend[u]--;
            if (avm_cs[u] && !waitreq[u]) begin
                if (log_n[u] < 128) begin
                    log_a[u][log_n[u]] = avm_addr[u];
                    log_w[u][log_n[u]] = avm_write[u];
                    log_d[u][log_n[u]] = avm_write[u] ? avm_wd[u] : 32'd0;
                    log_n[u]++;
                end
                if (avm_read[u]) begin
                    pend_val[u] = slave_rd(u, avm_addr[u]);
                    if (u == 1) pend[u] = 1;
                    if (avm_addr[u] == 4'd15) poll_cnt[u]++;
                end else begin
                    sregs[u][avm_addr[u]] = avm_wd[u];
                    if (avm_addr[u] == 4'd14) begin
                        if (avm_wd[u][0]) begin
                            bit [127:0] d;
                            d = model_dec({sregs[u][0], sregs[u][1], sregs[u][2], sregs[u][3]},
                                          {sregs[u][4], sregs[u][5], sregs[u][6], sregs[u][7]});
                            started[u] = 1'b1;
                            poll_cnt[u] = 0;
                            for (int w = 0; w < 4; w++) sregs[u][8 + w] = wslice(d, w);
                        end else begin
                            started[u] = 1'b0;
                        end
                    end
                end
            end
        end
        cyc++;
    end

    function automatic bit [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive one request; returns the posedge count of the acceptance edge.
    task automatic start_op(int u, bit [127:0] k, bit [127:0] m, int target, output int acc);
        @(negedge CLK);
        poll_target[u] = target;
        log_n[u] = 0;
        key[u] = k;
        msg_enc[u] = m;
        cmd_start[u] = 1'b1;
        @(negedge CLK);
        cmd_start[u] = 1'b0;
        acc = cyc;
        checks++;
        if (busy[u] !== 1'b1 || done[u] !== 1'b0) begin
            failures++;
            $display("FAIL busy_rise u%0d: busy=%b done=%b, required busy=1 done=0", u, busy[u], done[u]);
        end
    endtask

    // Wait (bounded) for DONE; lat is the cycle index after acceptance.
    task automatic wait_done(int u, int acc, output int lat);
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            if (done[u] === 1'b1) begin
                lat = cyc - acc + 1;
                break;
            end
            @(negedge CLK);
        end
        checks++;
        if (lat < 0) begin
            failures++;
            $display("FAIL done_timeout u%0d: DONE not seen in 3000 cycles, required DONE=1", u);
        end
    endtask

    // Compare the logged bus traffic against the expected full sequence.
    task automatic check_log(int u, string name, bit [127:0] k, bit [127:0] m, int npoll);
        int bad, polls, n_exp;
        bit [3:0] ea;
        bit ew;
        bit [31:0] ed;
        bad = 0;
        polls = 0;
        n_exp = 14 + npoll;
        if (log_n[u] != n_exp) bad++;
        for (int i = 0; i < log_n[u] && i < n_exp; i++) begin
            ed = 32'd0;
            if (i < 4)                 begin ea = 4'(i);     ew = 1'b1; ed = wslice(k, i); end
            else if (i < 8)            begin ea = 4'(i);     ew = 1'b1; ed = wslice(m, i - 4); end
            else if (i == 8)           begin ea = 4'd14;     ew = 1'b1; ed = 32'd1; end
            else if (i < 9 + npoll)    begin ea = 4'd15;     ew = 1'b0; end
            else if (i < 13 + npoll)   begin ea = 4'(i - 1 - npoll); ew = 1'b0; end
            else                       begin ea = 4'd14;     ew = 1'b1; end
            if (log_a[u][i] != ea || log_w[u][i] != ew || log_d[u][i] != ed) bad++;
        end
        for (int i = 0; i < log_n[u] && i < 128; i++)
            if (log_a[u][i] == 4'd15 && !log_w[u][i]) polls++;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL %s log_seq u%0d: %0d entries of %0d differ, required 0 (expected %0d xacts)", name, u, bad, log_n[u], n_exp);
        end
        checks++;
        if (polls !== npoll) begin
            failures++;
            $display("FAIL %s poll_count u%0d: %0d reads of addr 15, required %0d", name, u, polls, npoll);
        end
    endtask

    // Full operation with result, flag, traffic and optional latency checks.
    task automatic run_op(int u, string name, bit [127:0] k, bit [127:0] m, int target, bit chk_lat);
        int acc, lat;
        start_op(u, k, m, target, acc);
        wait_done(u, acc, lat);
        checks++;
        if (msg_dec[u] !== model_dec(k, m) || busy[u] !== 1'b0 || err[u] !== 1'b0) begin
            failures++;
            $display("FAIL %s result u%0d: msg_dec=%h busy=%b err=%b, required msg_dec=%h busy=0 err=0", name, u, msg_dec[u], busy[u], err[u], model_dec(k, m));
        end
        if (chk_lat) begin
            checks++;
            if (lat !== 15 + target) begin
                failures++;
                $display("FAIL %s latency u%0d: DONE in cycle %0d, required %0d", name, u, lat, 15 + target);
            end
        end
        check_log(u, name, k, m, target);
        $display("op %s u%0d polls=%0d lat=%0d msg_dec=%h", name, u, target, lat, msg_dec[u]);
    endtask

    task automatic check_idle_outputs(string name, int u);
        checks++;
        if ({avm_cs[u], avm_read[u], avm_write[u], avm_addr[u], avm_be[u], avm_wd[u]} !== '0 ||
            busy[u] !== 1'b0 || done[u] !== 1'b0 || err[u] !== 1'b0) begin
            failures++;
            $display("FAIL %s u%0d: cs=%b rd=%b wr=%b addr=%h be=%h wd=%h busy=%b done=%b err=%b, required all 0",
                     name, u, avm_cs[u], avm_read[u], avm_write[u], avm_addr[u], avm_be[u], avm_wd[u], busy[u], done[u], err[u]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge CLK);
        for (int u = 0; u < 2; u++) begin
            check_idle_outputs("reset_state", u);
            checks++;
            if (msg_dec[u] !== 128'd0) begin
                failures++;
                $display("FAIL reset_msg_dec u%0d: %h, required 0", u, msg_dec[u]);
            end
        end
        rst = 1'b0;
        $display("reset done");
    endtask

    task automatic test_fips_timing();
        run_op(0, "fips", FIPS_KEY, FIPS_ENC, 3, 1'b1);
    endtask

    task automatic test_random_l0();
        for (int i = 0; i < 4; i++)
            run_op(0, "rand_l0", rand128(), rand128(), int'($urandom_range(1, 6)), 1'b1);
    endtask

    task automatic test_stall_latency();
        wr_rand = 1'b1;
        run_op(1, "stall_fips", FIPS_KEY, FIPS_ENC, 2, 1'b0);
        for (int i = 0; i < 4; i++)
            run_op(1, "stall_rand", rand128(), rand128(), int'($urandom_range(1, 4)), 1'b0);
        wr_rand = 1'b0;
        checks++;
        if (viol[1] !== 0) begin
            failures++;
            $display("FAIL stall_protocol u1: %0d violations, required 0", viol[1]);
        end
    endtask

    task automatic test_busy_ignore();
        bit [127:0] k, m;
        int acc, lat, starts;
        k = rand128();
        m = rand128();
        @(negedge CLK);
        poll_target[0] = 2;
        log_n[0] = 0;
        key[0] = k;
        msg_enc[0] = m;
        cmd_start[0] = 1'b1;
        @(negedge CLK);
        acc = cyc;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            if (done[0] === 1'b1) begin lat = cyc - acc + 1; break; end
            key[0] = rand128();
            msg_enc[0] = rand128();
            @(negedge CLK);
        end
        @(negedge CLK);
        cmd_start[0] = 1'b0;
        repeat (3) @(negedge CLK);
        starts = 0;
        for (int i = 0; i < log_n[0] && i < 128; i++)
            if (log_a[0][i] == 4'd14 && log_w[0][i] && log_d[0][i] == 32'd1) starts++;
        checks++;
        if (starts !== 1 || busy[0] !== 1'b0 || done[0] !== 1'b1) begin
            failures++;
            $display("FAIL busy_ignore u0: starts=%0d busy=%b done=%b, required starts=1 busy=0 done=1", starts, busy[0], done[0]);
        end
        checks++;
        if (lat !== 17 || msg_dec[0] !== model_dec(k, m)) begin
            failures++;
            $display("FAIL busy_ignore_result u0: lat=%0d msg_dec=%h, required lat=17 msg_dec=%h", lat, msg_dec[0], model_dec(k, m));
        end
        check_log(0, "busy_ignore", k, m, 2);
        $display("op busy_ignore u0 starts=%0d lat=%0d msg_dec=%h", starts, lat, msg_dec[0]);
    endtask

    task automatic test_reset_mid();
        int acc;
        start_op(0, rand128(), rand128(), NEVER, acc);
        repeat (11) @(negedge CLK);
        rst = 1'b1;
        @(posedge CLK);
        #1;
        check_idle_outputs("reset_mid", 0);
        @(negedge CLK);
        rst = 1'b0;
        $display("reset during poll applied");
        run_op(0, "after_reset", rand128(), rand128(), 2, 1'b1);
    endtask

`ifdef AES_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int acc, lat;
        rst = 1'b1;
        repeat (2) @(negedge CLK);
        rst = 1'b0;
        start_op(0, rand128(), rand128(), NEVER, acc);
        wait_done(0, acc, lat);
        checks++;
        if (err[0] !== 1'b1 || done[0] !== 1'b1 || busy[0] !== 1'b0 || msg_dec[0] !== 128'd0) begin
            failures++;
            $display("FAIL timeout_flags u0: err=%b done=%b busy=%b msg_dec=%h, required err=1 done=1 busy=0 msg_dec=0", err[0], done[0], busy[0], msg_dec[0]);
        end
        checks++;
        if (log_n[0] < 1 || log_a[0][log_n[0] - 1] !== 4'd14 || log_w[0][log_n[0] - 1] !== 1'b1 || log_d[0][log_n[0] - 1] !== 32'd0) begin
            failures++;
            $display("FAIL timeout_clear_write u0: last xact not write addr 14 data 0 (n=%0d)", log_n[0]);
        end
        $display("op timeout u0 lat=%0d err=%b", lat, err[0]);
        run_op(0, "after_timeout", rand128(), rand128(), 1, 1'b1);
    endtask
`endif

    initial begin
        rst = 1'b1;
        cmd_start = '0;
        key = '0;
        msg_enc = '0;
        waitreq = '0;
        avm_rd = '0;
        for (int u = 0; u < 2; u++) begin
            pend[u] = -1;
            poll_target[u] = NEVER;
        end
        test_reset();
        test_fips_timing();
        test_random_l0();
        test_stall_latency();
        test_busy_ignore();
        test_reset_mid();
`ifdef AES_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (both_hi !== 0 || viol[0] !== 0) begin
            failures++;
            $display("FAIL global_invariants: busy&done cycles=%0d u0 violations=%0d, required 0 and 0", both_hi, viol[0]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_avalon_master.md
# aes_avalon_master

Avalon-MM initiator that drives the AES decryption register-file slave from hardware instead of software. It loads the 128-bit key and the encrypted message, sets the start register and polls the done register. It then reads back the decrypted message, clears start and presents the result on a parallel port. It sits between any fabric-side requester (test logic, DMA, button FSM) and the AES slave's Avalon-MM port.

## Interface
- READ_LATENCY, 0: cycles from read acceptance to valid AVM_READDATA (0–3); 0 matches the AES slave's combinational read path.
- TIMEOUT_CYCLES, 4096: poll budget in cycles; used only with the timeout feature.
- CLK  in  1  clock
- RESET  in  1  reset, synchronous, active-high; clock CLK.
- CMD_START  in  1  request pulse; accepted only when BUSY=0
- KEY  in  128  AES key, sampled on acceptance
- MSG_ENC  in  128  ciphertext, sampled on acceptance
- MSG_DEC  out  128  decrypted message, held until next acceptance
- BUSY  out  1  high from the cycle after acceptance until DONE rises
- DONE  out  1  level; set on completion, cleared on next acceptance
- ERR  out  1  poll timeout flag (0 when timeout compiled out)
- AVM_CS  out  1  chip select, high with AVM_READ or AVM_WRITE
- AVM_READ  out  1  read strobe
- AVM_WRITE  out  1  write strobe
- AVM_ADDR  out  4  word address
- AVM_BYTE_EN  out  4  always 4'hF during a transaction, 0 otherwise
- AVM_WRITEDATA  out  32  write data
- AVM_READDATA  in  32  read data
- AVM_WAITREQUEST  in  1  slave stall; tie 0 for the AES slave

## Operation
- Register map: 0–3 key, 4–7 encrypted message, 8–11 decrypted message, 14 start (bit 0), 15 done (bit 0). Word n carries bits [127-32n -: 32], so addr 0/4/8 carry [127:96].
- States: IDLE → WR_KEY (addr 0..3) → WR_MSG (4..7) → WR_START (14, data 1) → POLL (read 15) → RD_DEC (8..11) → WR_CLR (14, data 0) → FIN → IDLE.
- POLL repeats until READDATA[0]=1. Each poll read is a separate transaction; no gap cycle.
- RD_DEC stores word k into MSG_DEC[127-32k -: 32] as it arrives.
- FIN sets DONE and clears BUSY, then returns to IDLE.
- CMD_START while BUSY=1 is ignored. CMD_START in the FIN cycle is also ignored.
- Reset values: all AVM_* outputs 0, MSG_DEC 0, BUSY 0, DONE 0, ERR 0, state IDLE.
- A RESET mid-operation aborts at the next edge, with no completion of the transaction in flight.

## Timing
- A transaction is asserted with strobes/address/data stable. It is accepted on the first rising edge with AVM_WAITREQUEST=0.
- Writes complete on acceptance.
- For READ_LATENCY=0, read data is sampled in the acceptance cycle. Otherwise it is sampled exactly READ_LATENCY cycles later, with strobes low in between.
- One outstanding transaction maximum; the next one may start the cycle after completion.
- Minimum latency at WAITREQUEST=0, READ_LATENCY=0: acceptance edge → first write next cycle.
  - 4+4+1 writes, N poll reads, 4 reads, 1 write.
  - DONE high in cycle 15+N after acceptance.
- BUSY and DONE are never high together.

## Configuration
- AES_MASTER_TIMEOUT_EN defined:
  - A counter runs during POLL.
  - If it reaches TIMEOUT_CYCLES without done=1, the block writes 0 to address 14, sets ERR=1, DONE=1 and BUSY=0, and leaves MSG_DEC unchanged.
  - ERR clears on next acceptance.
- Undefined: no counter, polls indefinitely, ERR tied 0.

## Structure
- Package aes_master_pkg holds:
  - the state enum;
  - address constants ADDR_KEY0=0, ADDR_MSG0=4, ADDR_DEC0=8, ADDR_START=14, ADDR_DONE=15;
  - the word-slice helper function.
- Sub-module avm_single_xact is a one-transaction engine:
  - takes req/rd/addr/wdata in, gives ack/rdata out;
  - handles WAITREQUEST and READ_LATENCY;
  - the top FSM sequences it.

## Test plan
- FIPS-197 vector against the real AES slave: KEY=000102030405060708090a0b0c0d0e0f, MSG_ENC=69c4e0d86a7b0430d8cdb78070b4c55a → MSG_DEC=00112233445566778899aabbccddeeff, DONE=1, ERR=0. Write sequence is addr 0..7, 14, then reads of 15…, 8..11, then write 14=0.
- Bus-model slave with done after 3 polls, WAITREQUEST=0 → DONE in cycle 18 after acceptance, and exactly 3 reads of addr 15.
- Random WAITREQUEST (50%), READ_LATENCY=2 → identical MSG_DEC, address/data stable while stalled, never two outstanding reads.
- CMD_START pulsed every cycle during an operation → one operation only, and KEY changes after acceptance do not alter written data.
- RESET asserted during POLL → next cycle all AVM_* 0, BUSY=0, DONE=0. A new CMD_START then completes normally.
- With AES_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave done never set → ERR=1, DONE=1, final write addr 14 data 0, MSG_DEC=0.
